// File: rtl/au_neg_s_pkg.sv
// Shared types and sizing helpers for the digit-serial conditional negator.
// Optional overflow output is enabled by defining AU_NEG_S_OVF_EN.
package au_neg_s_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int ndig(input int width, input int digit);
    return width / digit;
  endfunction

  // Counter must be able to hold NDIG itself, hence NDIG+1.
  function automatic int cnt_width(input int width, input int digit);
    return $clog2(width / digit + 1);
  endfunction

endpackage

// File: rtl/au_neg_s_if.sv
// Operand/result handshake bundle for au_neg_s; ovf exists only with AU_NEG_S_OVF_EN.
interface au_neg_s_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic             neg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] z;
  logic             busy;
`ifdef AU_NEG_S_OVF_EN
  logic             ovf;

  modport master (output in_valid, a, neg, out_ready,
                  input  in_ready, out_valid, z, busy, ovf);
  modport slave  (input  in_valid, a, neg, out_ready,
                  output in_ready, out_valid, z, busy, ovf);
`else
  modport master (output in_valid, a, neg, out_ready,
                  input  in_ready, out_valid, z, busy);
  modport slave  (input  in_valid, a, neg, out_ready,
                  output in_ready, out_valid, z, busy);
`endif
endinterface

// File: rtl/au_neg_s_digit.sv
// One DIGIT-bit slice of a conditional negate: z_d = (a_d ^ neg) + cin, combinational.
// No state, no handshake; carry out feeds the next digit through the parent's carry flop.
module au_neg_s_digit #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] a_d,
  input  logic             neg,
  input  logic             cin,
  output logic [DIGIT-1:0] z_d,
  output logic             cout
);

  logic [DIGIT:0] sum;

  assign sum         = {1'b0, a_d ^ {DIGIT{neg}}} + {{DIGIT{1'b0}}, cin};
  assign {cout, z_d} = sum;

endmodule

// File: rtl/au_neg_s.sv
// Digit-serial z = neg ? -a : a, LSB first; result valid WIDTH/DIGIT cycles after accept,
// held in DONE until out_ready; no input accepted until the cycle after that. AU_NEG_S_OVF_EN adds ovf.
module au_neg_s
  import au_neg_s_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input logic       clk,
  input logic       rst,
  au_neg_s_if.slave bus
);

  localparam int NDIG = ndig(WIDTH, DIGIT);
  localparam int CW   = cnt_width(WIDTH, DIGIT);

  localparam logic [1:0]    S_IDLE = IDLE;
  localparam logic [1:0]    S_RUN  = RUN;
  localparam logic [1:0]    S_DONE = DONE;
  localparam logic [CW-1:0] LAST   = CW'(NDIG - 1);

  generate
    if (WIDTH < 2 || DIGIT < 1 || DIGIT > WIDTH || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $error("au_neg_s: WIDTH must be >= 2 and a multiple of DIGIT");
    end
  endgenerate

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] result;
  logic             nreg;
  logic             carry;
  logic [DIGIT-1:0] digit;
  logic [DIGIT-1:0] z_d;
  logic             cout;

  assign digit = opnd[DIGIT-1:0];

  au_neg_s_digit #(.DIGIT(DIGIT)) u_digit (
    .a_d  (digit),
    .neg  (nreg),
    .cin  (carry),
    .z_d  (z_d),
    .cout (cout)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      opnd   <= '0;
      result <= '0;
      nreg   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            opnd  <= bus.a;
            nreg  <= bus.neg;
            carry <= bus.neg;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          // New digit enters at the top; after NDIG shifts the word is LSB-aligned.
          result <= WIDTH'({z_d, result} >> DIGIT);
          opnd   <= opnd >> DIGIT;
          carry  <= cout;
          cnt    <= cnt + CW'(1);
          if (cnt == LAST) state <= S_DONE;
        end
        S_DONE: begin
          if (bus.out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef AU_NEG_S_OVF_EN
  localparam logic [DIGIT-1:0] ONE_D    = 1;
  localparam logic [DIGIT-1:0] MSB_MASK = ONE_D << (DIGIT - 1);

  logic low_zero;
  logic ovf_r;

  // Most-negative value: every digit zero except the last, which holds only the MSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      low_zero <= 1'b1;
      ovf_r    <= 1'b0;
    end else if (state == S_IDLE && bus.in_valid) begin
      low_zero <= 1'b1;
      ovf_r    <= 1'b0;
    end else if (state == S_RUN) begin
      if (cnt == LAST) ovf_r <= nreg & low_zero & (digit == MSB_MASK);
      else             low_zero <= low_zero & (digit == '0);
    end
  end

  assign bus.ovf = ovf_r;
`endif

  assign bus.in_ready  = (state == S_IDLE) & ~rst;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.z         = result;

endmodule

// File: tb/tb_au_neg_s.sv
// Scoreboard bench for au_neg_s (WIDTH=8, DIGIT=2): directed vectors, backpressure, abort, full sweep.
module tb_au_neg_s;

  localparam int WIDTH = 8;
  localparam int DIGIT = 2;
  localparam int NDIG  = WIDTH / DIGIT;

  typedef struct packed {
    logic [WIDTH-1:0] z;
    logic             ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nchk = 0;
  int   nerr = 0;
  int   cyc = 0;
  int   acc_cyc = -1;
  int   rdy_mode = 0;
  logic prev_ov = 1'b0;
  exp_t sb[$];
  exp_t e;

  au_neg_s_if #(.WIDTH(WIDTH)) bus ();

  au_neg_s #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // out_ready driver: 0 = always ready, 1 = random stalls, 2 = held low
  always @(posedge clk) begin
    #2;
    case (rdy_mode)
      0:       bus.out_ready = 1'b1;
      1:       bus.out_ready = 1'($urandom_range(0, 1));
      default: bus.out_ready = 1'b0;
    endcase
  end

  // Monitor: latency of each result and in-order scoreboard compare at every handshake
  always @(negedge clk) begin
    if (rst) begin
      acc_cyc = -1;
      prev_ov = 1'b0;
    end else begin
      if (bus.in_valid && bus.in_ready) acc_cyc = cyc + 1;
      if (bus.out_valid && !prev_ov) check("latency", 32'(cyc - acc_cyc), NDIG);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", 1, 0);
        end else begin
          e = sb.pop_front();
          check("z", bus.z, e.z);
`ifdef AU_NEG_S_OVF_EN
          check("ovf", bus.ovf, e.ovf);
`endif
        end
      end
      prev_ov = bus.out_valid;
    end
  end

  task automatic do_op(input logic [7:0] av, input logic nv, input logic [7:0] ez,
                       input logic eo, input bit push);
    int n = 0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.a        = av;
    bus.neg      = nv;
    @(negedge clk);
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!bus.in_ready) begin
      check("accept_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      if (push) sb.push_back(exp_t'({ez, eo}));
      #1;
      bus.in_valid = 1'b0;
      bus.a        = ~av;
      bus.neg      = ~nv;
    end
  endtask

  task automatic wait_out();
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) check("out_timeout", 0, 1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((sb.size() != 0 || bus.out_valid) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || bus.out_valid) check("drain_timeout", 0, 1);
  endtask

  initial begin
    logic [7:0] av;
    logic [7:0] ez;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.neg       = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_z", bus.z, 0);
    check("rst_busy", bus.busy, 0);
`ifdef AU_NEG_S_OVF_EN
    check("rst_ovf", bus.ovf, 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", bus.in_ready, 1);
    check("idle_busy", bus.busy, 0);

    // Basic values, including zero and the most-negative operand
    do_op(8'h01, 1'b1, 8'hFF, 1'b0, 1'b1);
    drain();
    do_op(8'h00, 1'b1, 8'h00, 1'b0, 1'b1);
    do_op(8'h5A, 1'b0, 8'h5A, 1'b0, 1'b1);
    do_op(8'h80, 1'b1, 8'h80, 1'b1, 1'b1);
    do_op(8'h80, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(8'hFF, 1'b1, 8'h01, 1'b0, 1'b1);
    drain();

    // Backpressure: result held, new requests ignored, re-accept one cycle after handshake
    rdy_mode = 2;
    do_op(8'h3C, 1'b1, 8'hC4, 1'b0, 1'b1);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = 8'hAA;
      bus.neg      = 1'b1;
      @(negedge clk);
      check("stall_z", bus.z, 8'hC4);
      check("stall_in_ready", bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_busy", bus.busy, 1);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    rdy_mode     = 0;
    @(negedge clk);
    check("hs_in_ready_before", bus.in_ready, 0);
    @(negedge clk);
    check("hs_in_ready_after", bus.in_ready, 1);
    check("hs_out_valid_after", bus.out_valid, 0);

    // Abort after the second RUN edge; nothing must come out for it
    do_op(8'h33, 1'b1, 8'hCD, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_out", bus.out_valid, 0);
    end
    do_op(8'h7F, 1'b1, 8'h81, 1'b0, 1'b1);
    drain();

    // Full operand sweep under random output stalls
    rdy_mode = 1;
    for (int i = 0; i < 256; i++) begin
      for (int n = 0; n < 2; n++) begin
        av = 8'(i);
        ez = (n == 1) ? (~av + 8'd1) : av;
        do_op(av, 1'(n), ez, (n == 1) && (av == 8'h80), 1'b1);
      end
    end
    drain();
    rdy_mode = 0;
    check("lost_ops", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

endmodule
